// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: register-file geometry and named register indices.
package mips_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int ADDR_WIDTH = 5;

   localparam logic [ADDR_WIDTH-1:0] REG_ZERO = 5'd0;
   localparam logic [ADDR_WIDTH-1:0] REG_AT   = 5'd1;
   localparam logic [ADDR_WIDTH-1:0] REG_V0   = 5'd2;
   localparam logic [ADDR_WIDTH-1:0] REG_A0   = 5'd4;
   localparam logic [ADDR_WIDTH-1:0] REG_T0   = 5'd8;
   localparam logic [ADDR_WIDTH-1:0] REG_T1   = 5'd9;
   localparam logic [ADDR_WIDTH-1:0] REG_S0   = 5'd16;
   localparam logic [ADDR_WIDTH-1:0] REG_SP   = 5'd29;
   localparam logic [ADDR_WIDTH-1:0] REG_RA   = 5'd31;

endpackage

// File: rtl/mips_register_file_32bit_register.sv
// One general-purpose register: enable flop with asynchronous active-high clear.
module mips_register_file_32bit_register #(
   parameter int DATA_WIDTH = mips_pkg::DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [DATA_WIDTH-1:0] d,
   output logic [DATA_WIDTH-1:0] q
);

   // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         q <= '0;
      else if (enable)
         q <= d;
   end

endmodule

// File: rtl/mips_register_file.sv
// 32 x 32-bit MIPS register file: two combinational read ports, one write port,
// hardwired zero register, optional write-to-read forwarding and a committed-write counter.
module mips_register_file
   import mips_pkg::*;
#(
   parameter int DATA_WIDTH = mips_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = mips_pkg::ADDR_WIDTH,
   parameter int BYPASS     = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] read_addr_A,
   input  logic [ADDR_WIDTH-1:0] read_addr_B,
   output logic [DATA_WIDTH-1:0] read_data_A,
   output logic [DATA_WIDTH-1:0] read_data_B,
   input  logic                  write_enable,
   input  logic [ADDR_WIDTH-1:0] write_addr,
   input  logic [DATA_WIDTH-1:0] write_data,
   output logic [15:0]           write_count
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] reg_q [DEPTH];
   logic                  write_valid;

   assign write_valid = write_enable && (write_addr != ADDR_WIDTH'(REG_ZERO));

   // Register 0 has no storage; it is a constant zero source for the read muxes.
   assign reg_q[0] = '0;

   for (genvar i = 1; i < DEPTH; i++) begin : g_reg
      logic sel;
      assign sel = write_valid && (write_addr == ADDR_WIDTH'(i));

      mips_register_file_32bit_register #(
         .DATA_WIDTH (DATA_WIDTH)
      ) u_reg (
         .clk    (clk),
         .reset  (reset),
         .enable (sel),
         .d      (write_data),
         .q      (reg_q[i])
      );
   end

   // Forwarding is suppressed during reset so the ports read zero while it is held.
   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      read_data_A = reg_q[read_addr_A];
      read_data_B = reg_q[read_addr_B];
      if (BYPASS != 0 && !reset && write_valid) begin
         if (read_addr_A == write_addr) read_data_A = write_data;
         if (read_addr_B == write_addr) read_data_B = write_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         write_count <= '0;
      else if (write_valid)
         write_count <= write_count + 16'd1;
   end

endmodule

// File: tb/tb_mips_register_file.sv
// Directed bench for mips_register_file: one instance per BYPASS mode, shared stimulus.
module tb_mips_register_file;
   import mips_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  read_addr_A, read_addr_B, write_addr;
   logic        write_enable;
   logic [31:0] write_data;
   logic [31:0] a0, b0, a1, b1;
   logic [15:0] cnt0, cnt1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mips_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(0)) dut0 (
      .clk (clk), .reset (reset),
      .read_addr_A (read_addr_A), .read_addr_B (read_addr_B),
      .read_data_A (a0), .read_data_B (b0),
      .write_enable (write_enable), .write_addr (write_addr), .write_data (write_data),
      .write_count (cnt0)
   );

   mips_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1)) dut1 (
      .clk (clk), .reset (reset),
      .read_addr_A (read_addr_A), .read_addr_B (read_addr_B),
      .read_data_A (a1), .read_data_B (b1),
      .write_enable (write_enable), .write_addr (write_addr), .write_data (write_data),
      .write_count (cnt1)
   );

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [4:0]  ra;
      logic [4:0]  rb;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
      logic [15:0] exp_cnt;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_both(input string name, input logic [31:0] exp_a, input logic [31:0] exp_b,
                             input logic [15:0] exp_cnt);
      check({name, " bp0 A"}, a0, exp_a);
      check({name, " bp0 B"}, b0, exp_b);
      check({name, " bp1 A"}, a1, exp_a);
      check({name, " bp1 B"}, b1, exp_b);
      check({name, " bp0 count"}, {16'd0, cnt0}, {16'd0, exp_cnt});
      check({name, " bp1 count"}, {16'd0, cnt1}, {16'd0, exp_cnt});
   endtask

   initial begin
      vecs[0] = '{1'b1, REG_T0,   32'h1234_5678, REG_T0,   REG_ZERO, 32'h1234_5678, 32'h0,         16'd1};
      vecs[1] = '{1'b1, REG_RA,   32'hCAFE_BABE, REG_T0,   REG_RA,   32'h1234_5678, 32'hCAFE_BABE, 16'd2};
      vecs[2] = '{1'b1, REG_ZERO, 32'hFFFF_FFFF, REG_ZERO, REG_ZERO, 32'h0,         32'h0,         16'd2};
      vecs[3] = '{1'b0, 5'd3,     32'hAAAA_5555, 5'd3,     REG_RA,   32'h0,         32'hCAFE_BABE, 16'd2};
      vecs[4] = '{1'b1, REG_S0,   32'h0000_0001, REG_S0,   REG_T0,   32'h1,         32'h1234_5678, 16'd3};
      vecs[5] = '{1'b1, REG_T0,   32'hFFFF_0000, REG_T0,   REG_T0,   32'hFFFF_0000, 32'hFFFF_0000, 16'd4};
      vecs[6] = '{1'b1, REG_T1,   32'h0000_0001, REG_T1,   REG_RA,   32'h1,         32'hCAFE_BABE, 16'd5};

      reset = 1'b1;
      write_enable = 1'b0;
      write_addr = '0;
      write_data = '0;
      read_addr_A = '0;
      read_addr_B = '0;
      #12;
      for (int r = 0; r < 32; r++) begin
         read_addr_A = 5'(r);
         read_addr_B = 5'(31 - r);
         #1;
         check_both($sformatf("reset r%0d", r), 32'h0, 32'h0, 16'd0);
      end
      @(negedge clk);
      reset = 1'b0;

      // Table: drive at negedge, compare one step after the following rising edge.
      for (int v = 0; v < 7; v++) begin
         @(negedge clk);
         write_enable = vecs[v].we;
         write_addr   = vecs[v].wa;
         write_data   = vecs[v].wd;
         read_addr_A  = vecs[v].ra;
         read_addr_B  = vecs[v].rb;
         @(posedge clk);
         #1;
         check_both($sformatf("vec%0d", v), vecs[v].exp_a, vecs[v].exp_b, vecs[v].exp_cnt);
      end

      // Same-cycle hazard on $t1 (holds 1): overwrite with 2 while reading it on both ports.
      @(negedge clk);
      write_enable = 1'b1;
      write_addr   = REG_T1;
      write_data   = 32'h2;
      read_addr_A  = REG_T1;
      read_addr_B  = REG_T1;
      #1;
      check("hazard pre bp0 A", a0, 32'h1);
      check("hazard pre bp0 B", b0, 32'h1);
      check("hazard pre bp1 A", a1, 32'h2);
      check("hazard pre bp1 B", b1, 32'h2);
      @(posedge clk);
      #1;
      check_both("hazard post", 32'h2, 32'h2, 16'd6);

      // Load reg 5, then assert reset between edges: it must clear without a clock edge.
      @(negedge clk);
      write_addr  = 5'd5;
      write_data  = 32'hDEAD_BEEF;
      read_addr_A = 5'd5;
      read_addr_B = REG_T0;
      @(posedge clk);
      #1;
      check_both("load r5", 32'hDEAD_BEEF, 32'hFFFF_0000, 16'd7);
      write_enable = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check_both("async reset", 32'h0, 32'h0, 16'd0);

      // Write attempted on an edge while reset is held is dropped, forwarding included.
      write_enable = 1'b1;
      write_addr   = 5'd10;
      write_data   = 32'h0000_0055;
      read_addr_A  = 5'd10;
      read_addr_B  = 5'd5;
      #1;
      check_both("reset bypass gate", 32'h0, 32'h0, 16'd0);
      @(posedge clk);
      #1;
      check_both("reset over write", 32'h0, 32'h0, 16'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check_both("first write after reset", 32'h0000_0055, 32'h0, 16'd1);

      // Counter wrap: from zero, 65535 writes reach FFFF and one more returns to 0.
      @(negedge clk);
      reset = 1'b1;
      write_enable = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      write_enable = 1'b1;
      write_addr   = REG_AT;
      read_addr_A  = REG_AT;
      read_addr_B  = 5'd10;
      for (int i = 0; i < 65535; i++) begin
         write_data = 32'(i);
         @(negedge clk);
      end
      write_enable = 1'b0;
      #1;
      check_both("count FFFF", 32'd65534, 32'h0, 16'hFFFF);
      write_enable = 1'b1;
      write_data   = 32'd65535;
      @(posedge clk);
      #1;
      check_both("count wrap", 32'd65535, 32'h0, 16'h0000);
      write_enable = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
